// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for core front-end blocks
package core_pkg;

  localparam int INST_CACHE_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_LOOKUP,
    IC_MISS,
    IC_RESPOND
  } inst_cache_state_t;

endpackage

// File: rtl/inst_cache_array.sv
// rtl/inst_cache_array.sv - direct-mapped tag/data storage with registered read and per-line valid flops
import core_pkg::*;

module inst_cache_array #(
  parameter int INDEX_BITS = INST_CACHE_INDEX_BITS,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data,
  input  logic                  clear_all
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];
  logic [LINES-1:0]    valid_q;

  // Storage carries no reset so it can map onto RAM; only the valid bits matter after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_index];
      rd_data <= data_mem[rd_index];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (clear_all) begin
        valid_q <= '0;
      end else if (wr_en) begin
        valid_q[wr_index] <= 1'b1;
      end
      if (rd_en) begin
        rd_valid <= valid_q[rd_index];
      end
    end
  end

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped one-word-per-line instruction cache with single outstanding fill
import core_pkg::*;

module inst_cache #(
  parameter int INDEX_BITS = INST_CACHE_INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic        req_valid,
  output logic [31:0] req_data,
  output logic        req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  input  logic        flush,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  inst_cache_state_t state_q, state_d;

  logic [31:2]         addr_q;
  logic [31:0]         data_q;
  logic                flush_pending_q;
  logic                flush_act;
  logic                accept;
  logic                lookup_hit;
  logic                fill;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_data;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  // A flush (live or deferred) owns the IDLE cycle; the request waits one cycle behind it.
  assign flush_act  = (state_q == IC_IDLE) && (flush || flush_pending_q);
  assign accept     = (state_q == IC_IDLE) && req_valid && !flush_act;
  assign lookup_hit = rd_valid && (rd_tag == addr_q[31:INDEX_BITS+2]);
  assign fill       = (state_q == IC_MISS) && mem_ready;
  assign req_data   = data_q;

  inst_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (accept),
    .rd_index  (req_addr[INDEX_BITS+1:2]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (fill),
    .wr_index  (addr_q[INDEX_BITS+1:2]),
    .wr_tag    (addr_q[31:INDEX_BITS+2]),
    .wr_data   (mem_data),
    .clear_all (flush_act)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (accept) begin
          state_d = IC_LOOKUP;
        end
      end
      IC_LOOKUP: begin
        state_d = lookup_hit ? IC_RESPOND : IC_MISS;
      end
      IC_MISS: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          state_d = IC_RESPOND;
        end
      end
      IC_RESPOND: begin
        req_ready = 1'b1;
        state_d   = IC_IDLE;
      end
      default: begin
        state_d = IC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q          <= '0;
      data_q          <= '0;
      mem_addr        <= '0;
      flush_pending_q <= 1'b0;
      hit_count       <= '0;
      miss_count      <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr[31:2];
      end
      if (state_q == IC_LOOKUP) begin
        if (lookup_hit) begin
          data_q    <= rd_data;
          hit_count <= hit_count + 32'd1;
        end else begin
          miss_count <= miss_count + 32'd1;
          mem_addr   <= {addr_q, 2'b00};
        end
      end
      if (fill) begin
        data_q <= mem_data;
      end
      if (flush_act) begin
        flush_pending_q <= 1'b0;
      end else if (flush) begin
        flush_pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - directed self-checking bench for inst_cache
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_valid = 1'b0;
  logic [31:0] req_data;
  logic        req_ready;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data = '0;
  logic        mem_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_cache #(.INDEX_BITS(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_addr   (req_addr),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One fetch with a bench-side memory that answers `delay` cycles after mem_valid appears.
  // flush_at: 0 = flush alongside req_valid, >0 = pulse in that cycle after acceptance, <0 = none.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] fill_word,
                       input int delay, input bit exp_miss, input logic [31:0] exp_data,
                       input int exp_lat, input int flush_at, input bit drop_early);
    int cyc = 0;
    int waited = 0;
    int lat = -1;
    bit saw_mem = 1'b0;
    @(negedge clk);
    req_addr  = addr;
    req_valid = 1'b1;
    flush     = (flush_at == 0);
    while (lat < 0 && cyc < 64) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0;
      flush = (flush_at > 0) && (cyc == flush_at);
      if (drop_early && cyc == 1) req_valid = 1'b0;
      if (req_ready) begin
        lat = cyc;
      end else if (mem_valid) begin
        if (!saw_mem) check_eq({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        saw_mem = 1'b1;
        waited++;
        if (waited > delay) begin
          mem_ready = 1'b1;
          mem_data  = fill_word;
        end
      end
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".data"}, req_data, exp_data);
    check_eq({tag, ".mem_used"}, {31'b0, saw_mem}, {31'b0, exp_miss});
    @(negedge clk);
    check_eq({tag, ".idle_after"}, {30'b0, req_ready, mem_valid}, 32'd0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check_eq("rst.req_ready", {31'b0, req_ready}, 32'd0);
    check_eq("rst.mem_valid", {31'b0, mem_valid}, 32'd0);
    check_eq("rst.mem_addr", mem_addr, 32'd0);
    check_eq("rst.req_data", req_data, 32'd0);
    check_eq("rst.hit_count", hit_count, 32'd0);
    check_eq("rst.miss_count", miss_count, 32'd0);
    reset = 1'b1;

    fetch("cold_miss", 32'h100, 32'hDEADBEEF, 3, 1'b1, 32'hDEADBEEF, 6, -1, 1'b0);
    check_eq("cold_miss.miss_count", miss_count, 32'd1);
    fetch("hit", 32'h100, 32'h0BADF00D, 0, 1'b0, 32'hDEADBEEF, 2, -1, 1'b0);
    check_eq("hit.hit_count", hit_count, 32'd1);

    fetch("conflict_a", 32'h200, 32'h22222222, 1, 1'b1, 32'h22222222, 4, -1, 1'b0);
    fetch("conflict_b", 32'h100, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF, 3, -1, 1'b0);
    check_eq("conflict.miss_count", miss_count, 32'd3);

    fetch("drop_early", 32'h200, 32'h22222222, 2, 1'b1, 32'h22222222, 5, -1, 1'b1);
    fetch("hit_after_drop", 32'h200, 32'h99999999, 0, 1'b0, 32'h22222222, 2, -1, 1'b0);
    check_eq("drop.hit_count", hit_count, 32'd2);

    fetch("flush_mid_fill", 32'h104, 32'h11110104, 4, 1'b1, 32'h11110104, 7, 3, 1'b0);
    fetch("miss_after_flush", 32'h104, 32'h5555AAAA, 0, 1'b1, 32'h5555AAAA, 3, -1, 1'b0);
    fetch("flush_idle_prio", 32'h104, 32'h66666666, 0, 1'b1, 32'h66666666, 4, 0, 1'b0);
    check_eq("flush.miss_count", miss_count, 32'd7);
    check_eq("flush.hit_count", hit_count, 32'd2);

    force dut.hit_count = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.hit_count;
    fetch("wrap_hit", 32'h104, 32'h00000000, 0, 1'b0, 32'h66666666, 2, -1, 1'b0);
    check_eq("wrap.hit_count", hit_count, 32'd0);
    check_eq("wrap.miss_count", miss_count, 32'd7);

    @(negedge clk);
    req_addr  = 32'h300;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_valid) break;
    end
    check_eq("rst_miss.mem_valid_before", {31'b0, mem_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_miss.mem_valid", {31'b0, mem_valid}, 32'd0);
    check_eq("rst_miss.mem_addr", mem_addr, 32'd0);
    check_eq("rst_miss.hit_count", hit_count, 32'd0);
    check_eq("rst_miss.miss_count", miss_count, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_data  = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ready = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (req_ready || mem_valid) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("rst_miss.late_ready_ignored", {31'b0, seen}, 32'd0);

    fetch("post_reset_a", 32'h104, 32'h77777777, 0, 1'b1, 32'h77777777, 3, -1, 1'b0);
    fetch("post_reset_b", 32'h100, 32'h88888888, 1, 1'b1, 32'h88888888, 4, -1, 1'b0);
    check_eq("post_reset.miss_count", miss_count, 32'd2);
    check_eq("post_reset.hit_count", hit_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter: INDEX_BITS, default 6, log2 of line count (one 32-bit word per line; 64 lines).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_addr  input  32  fetch word address from fetcher; bits [1:0] ignored.
REQ-005 req_valid  input  1  fetch request; held with stable req_addr until req_ready seen.
REQ-006 req_data  output  32  instruction word; valid only while req_ready=1.
REQ-007 req_ready  output  1  one-cycle pulse: req_data holds word for accepted request.
REQ-008 mem_addr  output  32  backing-memory word address.
REQ-009 mem_valid  output  1  backing-memory read request; held until mem_ready.
REQ-010 mem_data  input  32  backing-memory word; sampled when mem_ready=1.
REQ-011 mem_ready  input  1  one-cycle pulse completing a mem_valid request.
REQ-012 flush  input  1  invalidate all lines (one-cycle pulse sufficient).
REQ-013 hit_count, miss_count  output  32 each  wrapping performance counters.

Function
REQ-014 Address split: index = req_addr[INDEX_BITS+1:2], tag = req_addr[31:INDEX_BITS+2].
REQ-015 FSM states IDLE, LOOKUP, MISS, RESPOND; direct-mapped, one valid bit per line.
REQ-016 IDLE: req_valid=1 and no flush action -> latch req_addr, issue registered array read, go LOOKUP.
REQ-017 LOOKUP: valid bit set and tag equal -> hit: load data register from array, hit_count+1, go RESPOND.
REQ-018 LOOKUP: otherwise miss: miss_count+1, go MISS.
REQ-019 MISS: mem_valid=1, mem_addr = latched address with [1:0]=0; on mem_ready write mem_data/tag/valid into line, load data register with mem_data, go RESPOND.
REQ-020 RESPOND: req_ready=1, req_data = data register, unconditionally go IDLE next cycle.
REQ-021 Hit latency: req_ready asserted 2 cycles after the edge that first samples req_valid in IDLE.
REQ-022 Miss latency: req_ready asserted the cycle after the edge sampling mem_ready.
REQ-023 IDLE never accepts a request in the cycle following RESPOND unless req_valid=1 then; a consumer dropping req_valid after req_ready causes no further access.
REQ-024 req_ready, mem_valid are 0 in every state other than RESPOND and MISS respectively.
REQ-025 flush in IDLE: all valid bits cleared at that edge; flush takes priority over a simultaneous req_valid, which is accepted the following cycle.
REQ-026 flush outside IDLE: set flush_pending; in-flight request completes normally (fill still written); flush applied on first IDLE cycle, then flush_pending cleared.
REQ-027 Counters wrap 0xFFFFFFFF -> 0; flush does not clear them.
REQ-028 req_valid deasserted while in LOOKUP/MISS: request still completes and fills; req_ready still pulses.

Reset
REQ-029 reset=0 asynchronously forces: state IDLE, all valid bits 0, flush_pending 0, req_ready 0, req_data 0, mem_valid 0, mem_addr 0, counters 0.
REQ-030 Reset during MISS abandons the request: no array write, mem_valid drops immediately, late mem_ready ignored.
REQ-031 Data/tag storage contents need not be reset; only valid bits.

Structure
REQ-032 Shared package core_pkg holds inst_cache_state_t enum and INST_CACHE_INDEX_BITS default constant.
REQ-033 One sub-module inst_cache_array: tag/data storage, registered read port, single write port, valid bits in flops with clear-all input.
REQ-034 Fetcher connects req_* directly to its inst_mem_out_* ports; no glue logic.

Verification
REQ-035 Cold miss: req 0x00000100 -> mem_valid with mem_addr 0x00000100; mem_ready+0xDEADBEEF after 3 cycles -> req_ready pulse with 0xDEADBEEF, miss_count=1.
REQ-036 Hit: repeat req 0x00000100 -> req_ready exactly 2 cycles after acceptance, data 0xDEADBEEF, mem_valid never asserted, hit_count=1.
REQ-037 Conflict: fill 0x00000100 then 0x00000200 (same index, different tag) -> second misses; re-request 0x00000100 misses again, miss_count=3.
REQ-038 Flush during MISS: flush pulse mid-fill of 0x00000104 -> fill returns data; subsequent req 0x00000104 misses.
REQ-039 Reset mid-miss: reset=0 while mem_valid=1 -> mem_valid 0 same cycle; mem_ready after release causes no req_ready; all lines miss.
REQ-040 Counter wrap: preload hit_count 0xFFFFFFFF via force, one hit -> hit_count=0.
